// File: rtl/btc_nonce_sequencer.sv
// Nonce sequencer for a single SHA-256d mining core.
// Walks an inclusive, wrapping nonce range [job_nonce_base .. job_nonce_last],
// launching one core run per nonce and collecting reported hits in a small FIFO.
// Ports:
//   clk, rst                 - single clock, synchronous active-high reset
//   job_*                    - job control (start/abort pulses, range, stop-on-find) and status
//   core_*                   - handshake to the hashing core (start pulse, nonce, done/found/result)
//   res_*                    - result FIFO read side (valid/head/pop, occupancy, sticky overflow)
module btc_nonce_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_start,
    input  logic        job_abort,
    input  logic [31:0] job_nonce_base,
    input  logic [31:0] job_nonce_last,
    input  logic        job_stop_on_find,
    output logic        job_busy,
    output logic        job_done,
    output logic        job_timeout,
    output logic [31:0] job_nonce_cur,
    output logic        core_start,
    output logic [31:0] core_nonce_in,
    output logic        core_use_nonce_in,
    output logic        core_oneshot,
    input  logic        core_done,
    input  logic        core_nonce_found,
    input  logic [31:0] core_nonce_out,
    output logic        res_valid,
    output logic [31:0] res_nonce,
    input  logic        res_pop,
    output logic [4:0]  res_count,
    output logic        res_overflow
);

    localparam int unsigned NONCE_W = 32;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned WD_W    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t             state;
    logic [WD_W-1:0]    wdog;
    logic [NONCE_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic pop_ok;
    logic push_req;
    logic push_ok;
    logic fifo_full;
    logic wdog_expired;
    logic job_end;

    // The core is always driven with an explicit nonce in one-shot mode.
    assign core_use_nonce_in = 1'b1;
    assign core_oneshot      = 1'b1;
    assign core_nonce_in     = job_nonce_cur;

    // FIFO handshake; abort suppresses any push in the same cycle.
    assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop_ok       = res_pop && (count != '0);
    assign push_req     = (state == WAIT) && core_done && core_nonce_found && !job_abort;
    assign push_ok      = push_req && (!fifo_full || pop_ok);
    assign wdog_expired = (wdog == WD_W'(WDOG_CYCLES));
    assign job_end      = (core_nonce_found && job_stop_on_find) || (job_nonce_cur == job_nonce_last);

    assign res_valid = (count != '0);
    assign res_nonce = res_valid ? fifo_mem[rd_ptr] : '0;
    assign res_count = count;

    // Job FSM. The watchdog counts cycles since the current core_start,
    // so it equals N in the cycle N clocks after the start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wdog          <= '0;
            job_nonce_cur <= '0;
            job_done      <= 1'b0;
            job_timeout   <= 1'b0;
            job_busy      <= 1'b0;
            core_start    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_start) begin
                        job_nonce_cur <= job_nonce_base;
                        job_done      <= 1'b0;
                        job_timeout   <= 1'b0;
                        wdog          <= '0;
                        job_busy      <= 1'b1;
                        core_start    <= 1'b1;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (job_abort) begin
                        job_done <= 1'b1;
                        job_busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        wdog  <= wdog + WD_W'(1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (job_abort) begin
                        job_done <= 1'b1;
                        job_busy <= 1'b0;
                        state    <= IDLE;
                    end else if (core_done) begin
                        if (job_end) begin
                            job_done <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            job_nonce_cur <= job_nonce_cur + NONCE_W'(1);
                            wdog          <= '0;
                            core_start    <= 1'b1;
                            state         <= LAUNCH;
                        end
                    end else if (wdog_expired) begin
                        job_timeout <= 1'b1;
                        job_done    <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                FINISH: begin
                    job_done <= 1'b1;
                    job_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    job_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Result FIFO; a pop accepted in the same cycle frees room for a push when full.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            res_overflow <= 1'b0;
        end else begin
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok) begin
                fifo_mem[wr_ptr] <= core_nonce_out;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_W'(1);
            end
            if ((state == IDLE) && job_start) begin
                res_overflow <= 1'b0;
            end else if (push_req && !push_ok) begin
                res_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/btc_nonce_sequencer.md
BTC_NONCE_SEQUENCER -- requirements
Module: btc_nonce_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the number of result-FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter WDOG_CYCLES, default 65535, giving the maximum number of cycles per core run before timeout.
REQ-003 SHALL have ports: clk  in  1  single clock for all logic; rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have job ports: job_start  in  1  pulse, launch a job; job_abort  in  1  pulse, cancel the job; job_nonce_base  in  32  first nonce; job_nonce_last  in  32  last nonce (inclusive); job_stop_on_find  in  1  end the job at the first hit.
REQ-005 SHALL have status ports: job_busy  out  1; job_done  out  1  sticky; job_timeout  out  1  sticky; job_nonce_cur  out  32  nonce under test.
REQ-006 SHALL have core ports: core_start  out  1  one-cycle pulse; core_nonce_in  out  32; core_use_nonce_in  out  1  tied 1; core_oneshot  out  1  tied 1; core_done  in  1  one-cycle completion pulse; core_nonce_found  in  1  qualified by core_done; core_nonce_out  in  32.
REQ-007 SHALL have result ports: res_valid  out  1; res_nonce  out  32  FIFO head; res_pop  in  1; res_count  out  5; res_overflow  out  1  sticky.

Function
REQ-008 SHALL implement states IDLE, LAUNCH, WAIT and FINISH.
REQ-009 IDLE with job_start=1: load job_nonce_cur=job_nonce_base; clear job_done, job_timeout and res_overflow; go to LAUNCH. FIFO contents are kept.
REQ-010 job_start SHALL be ignored in every non-IDLE state.
REQ-011 LAUNCH: core_start=1 for exactly that cycle; clear the watchdog; go to WAIT.
REQ-012 core_start SHALL be asserted in the cycle after job_start is sampled.
REQ-013 core_nonce_in SHALL equal job_nonce_cur at all times and stay stable from LAUNCH through WAIT.
REQ-014 WAIT: the watchdog SHALL increment each cycle.
REQ-015 WAIT with core_done=1 and core_nonce_found=1: push core_nonce_out into the FIFO.
REQ-016 WAIT with core_done=1: if (core_nonce_found && job_stop_on_find) or job_nonce_cur==job_nonce_last, go to FINISH.
REQ-017 WAIT with core_done=1, otherwise: set job_nonce_cur = job_nonce_cur + 1 mod 2^32 and go to LAUNCH. The next core_start is therefore exactly 1 cycle after core_done.
REQ-018 WAIT with watchdog == WDOG_CYCLES and core_done=0: set job_timeout and go to FINISH with no push.
REQ-019 If core_done=1 in the same cycle the watchdog reaches WDOG_CYCLES, core_done SHALL win and no timeout is flagged.
REQ-020 The nonce range SHALL be inclusive and wrap modulo 2^32. Runs per job = ((last - base) mod 2^32) + 1. base==last gives one run. base>last wraps through 0xFFFFFFFF to 0.
REQ-021 FINISH: set job_done, go to IDLE. FINISH SHALL last exactly 1 cycle.
REQ-022 job_busy SHALL be 1 in LAUNCH, WAIT and FINISH, and 0 in IDLE.
REQ-023 job_abort in any non-IDLE state SHALL force IDLE next cycle and set job_done.
REQ-024 job_abort SHALL take priority over core_done and the watchdog; no push happens in an abort cycle.
REQ-025 job_abort in IDLE SHALL be ignored.
REQ-026 FIFO: res_valid = (res_count != 0); res_nonce = oldest entry; res_pop with res_valid removes it next cycle; res_pop when empty is ignored.
REQ-027 Push when full SHALL drop the nonce and set res_overflow, unless res_pop is accepted in the same cycle; then pop and push both succeed with no overflow.
REQ-028 FIFO read/write pointers SHALL wrap at FIFO_DEPTH.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL go to IDLE, empty the FIFO, and drive core_start=0, job_busy=0, job_done=0, job_timeout=0, res_overflow=0, res_valid=0, res_count=0, job_nonce_cur=0, res_nonce=0.
REQ-030 rst mid-job SHALL abandon the run with no job_done pulse, and SHALL override job_start, job_abort and res_pop in the same cycle.
REQ-031 core_use_nonce_in and core_oneshot SHALL stay 1 through reset.

Verification
REQ-032 Sweep: base=0x10, last=0x13, core_done 5 cycles after each core_start, hit on 0x12, stop_on_find=0 -> 4 core_starts with nonce_in 0x10..0x13; one FIFO entry 0x12; job_done set.
REQ-033 Stop on find: same as REQ-032 with stop_on_find=1 -> 3 core_starts; job_nonce_cur=0x12 at done.
REQ-034 Wrap: base=0xFFFFFFFE, last=0x1 -> nonce_in sequence FFFFFFFE, FFFFFFFF, 0, 1; then job_done.
REQ-035 Overflow: FIFO_DEPTH=4, 6 hits, no pops -> res_count=4, entries are the first 4 hits, res_overflow=1. Pop while full concurrent with a hit -> count stays 4, no overflow.
REQ-036 Watchdog: WDOG_CYCLES=20, core never done -> job_timeout=1 and job_done=1 at cycle 21 after core_start. Also core_done at cycle 20 -> no timeout.
REQ-037 Abort/reset: job_abort coincident with core_done+found -> no push, IDLE next cycle. rst in WAIT -> all outputs at reset values. job_start while busy -> no effect.
